// File: rtl/boolfn_pkg.sv
// rtl/boolfn_pkg.sv - shared types, reset mask and minterm decoder for the boolean-function sweeper
package boolfn_pkg;

  localparam int N_MAX     = 8;
  localparam int DEPTH_MAX = 2**N_MAX;

  localparam logic [15:0] DEFAULT_MASK = 16'hD0C4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Decoded at the widest supported size; narrower users zero-extend their mask to match.
  function automatic logic [DEPTH_MAX-1:0] minterm_dec(input logic [N_MAX-1:0] idx);
    logic [DEPTH_MAX-1:0] dec;
    dec      = '0;
    dec[idx] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/boolfn_eval.sv
// rtl/boolfn_eval.sv - combinational SoP and PoS evaluation of a truth-table mask at one minterm
module boolfn_eval
  import boolfn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int DEPTH = 2**N_IN
) (
  input  logic [DEPTH-1:0] mask,
  input  logic [N_IN-1:0]  idx,
  output logic             sop,
  output logic             pos
);

  logic [DEPTH_MAX-1:0] dec;
  logic [DEPTH_MAX-1:0] mask_ext;

  assign dec      = minterm_dec(N_MAX'(idx));
  assign mask_ext = DEPTH_MAX'(mask);

  // SoP: OR of the selected minterms; PoS: AND of maxterm clauses, each clause false only at its own cleared index.
  assign sop = |(dec & mask_ext);
  assign pos = &(mask_ext | ~dec);

endmodule

// File: rtl/boolfn_sweeper.sv
// rtl/boolfn_sweeper.sv - sweeps all minterms of a programmable truth table, streaming SoP/PoS beats
// Optional checker against an external combinational block is enabled by defining CHECK_EN.
module boolfn_sweeper
  import boolfn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int DEPTH = 2**N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [DEPTH-1:0] cfg_mask,
  input  logic             start,
  input  logic             loop,
  input  logic             stop,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_idx,
  output logic             out_sop,
  output logic             out_pos,
  output logic [N_IN:0]    ones_cnt,
  output logic             mismatch,
`ifdef CHECK_EN
  input  logic             chk_in,
  output logic [N_IN:0]    err_cnt,
`endif
  output logic             done
);

  localparam logic [DEPTH-1:0] MASK_RST = DEPTH'(DEFAULT_MASK);
  localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(DEPTH - 1);

  state_t           state;
  state_t           state_next;
  logic [DEPTH-1:0] mask_r;
  logic [N_IN-1:0]  idx;
  logic             loop_r;
  logic             stop_r;
  logic             launch;
  logic             accept;
  logic             last;
  logic             wrap;

  assign launch = (state == IDLE) && start;
  assign accept = (state == RUN) && out_ready;
  assign last   = (idx == IDX_LAST);
  // A stop arriving in the same cycle as the final beat still ends the sweep.
  assign wrap   = accept && last && loop_r && !(stop_r || stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (accept && last && !wrap) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r   <= MASK_RST;
      idx      <= '0;
      ones_cnt <= '0;
      mismatch <= 1'b0;
      loop_r   <= 1'b0;
      stop_r   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= accept && last;
      if (state == IDLE && cfg_we) mask_r <= cfg_mask;
      if (launch) begin
        idx      <= '0;
        ones_cnt <= '0;
        mismatch <= 1'b0;
        loop_r   <= loop;
        stop_r   <= 1'b0;
      end
      if (state == RUN && stop) stop_r <= 1'b1;
      if (accept) begin
        mismatch <= mismatch | (out_sop ^ out_pos);
        if (wrap) begin
          idx      <= '0;
          ones_cnt <= '0;
        end else begin
          ones_cnt <= ones_cnt + {{N_IN{1'b0}}, out_sop};
          if (!last) idx <= idx + N_IN'(1);
        end
      end
    end
  end

`ifdef CHECK_EN
  localparam logic [N_IN:0] ERR_MAX = (N_IN + 1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (launch) begin
      err_cnt <= '0;
    end else if (accept && (chk_in != mask_r[idx]) && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + (N_IN + 1)'(1);
    end
  end
`endif

  assign out_idx = idx;

  boolfn_eval #(
    .N_IN  (N_IN),
    .DEPTH (DEPTH)
  ) u_eval (
    .mask (mask_r),
    .idx  (idx),
    .sop  (out_sop),
    .pos  (out_pos)
  );

endmodule

// File: tb/tb_boolfn_sweeper.sv
// tb/tb_boolfn_sweeper.sv - randomized self-checking bench for boolfn_sweeper against a truth-table model
module tb_boolfn_sweeper;

  localparam int N_IN  = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [DEPTH-1:0] cfg_mask = '0;
  logic             start = 1'b0;
  logic             loop = 1'b0;
  logic             stop = 1'b0;
  logic             out_ready = 1'b0;
  logic             chk_in = 1'b0;
  logic             busy, out_valid, out_sop, out_pos, mismatch, done;
  logic [N_IN-1:0]  out_idx;
  logic [N_IN:0]    ones_cnt;
`ifdef CHECK_EN
  logic [N_IN:0]    err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int acc_q[$];
  int sop_q[$];
  logic [DEPTH-1:0] def_mask = 16'hD0C4;

  always #5 clk = ~clk;

  boolfn_sweeper #(.N_IN(N_IN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .start     (start),
    .loop      (loop),
    .stop      (stop),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_sop   (out_sop),
    .out_pos   (out_pos),
    .ones_cnt  (ones_cnt),
    .mismatch  (mismatch),
`ifdef CHECK_EN
    .chk_in    (chk_in),
    .err_cnt   (err_cnt),
`endif
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 sweeping, 2 finishing; ones is a popcount of the table up to the accepted index.
  int               m_phase = 0;
  int               m_idx = 0;
  int               m_ones = 0;
  int               m_err = 0;
  bit               m_done = 0;
  bit               m_loop = 0;
  bit               m_stop = 0;
  logic [DEPTH-1:0] m_mask = 16'hD0C4;

  function automatic int popcnt_upto(input logic [DEPTH-1:0] m, input int k);
    int c = 0;
    for (int i = 0; i <= k; i++) c += int'(m[i]);
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_ones = 0; m_err = 0;
      m_done = 0; m_loop = 0; m_stop = 0; m_mask = 16'hD0C4;
    end else begin
      m_done = 0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (cfg_we) m_mask = cfg_mask;
        if (start) begin
          m_phase = 1; m_idx = 0; m_ones = 0; m_err = 0; m_loop = loop; m_stop = 0;
        end
      end else begin
        if (stop) m_stop = 1;
        if (out_ready) begin
          if (chk_in !== m_mask[m_idx]) m_err = (m_err < DEPTH) ? m_err + 1 : DEPTH;
          m_ones = popcnt_upto(m_mask, m_idx);
          if (m_idx < DEPTH - 1) begin
            m_idx++;
          end else begin
            m_done = 1;
            if (m_loop && !m_stop) begin
              m_idx = 0; m_ones = 0;
            end else begin
              m_phase = 2;
            end
          end
        end
      end
    end
  end

  logic            prev_stall = 1'b0;
  logic [N_IN-1:0] prev_idx = '0;

  always @(negedge rst_n) prev_stall = 1'b0;

  always @(negedge clk) begin
    check("busy", busy, m_phase == 1);
    check("out_valid", out_valid, m_phase == 1);
    check("out_idx", out_idx, m_idx);
    check("ones_cnt", ones_cnt, m_ones);
    check("mismatch", mismatch, 1'b0);
    check("done", done, m_done);
`ifdef CHECK_EN
    check("err_cnt", err_cnt, m_err);
`endif
    if (out_valid) begin
      check("out_sop", out_sop, m_mask[m_idx]);
      check("out_pos", out_pos, m_mask[m_idx]);
    end
    if (prev_stall) check("stall_hold_idx", out_idx, prev_idx);
    prev_stall = out_valid && !out_ready;
    prev_idx   = out_idx;
    if (out_valid && out_ready) begin
      acc_q.push_back(int'(out_idx));
      if (out_sop) sop_q.push_back(int'(out_idx));
    end
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit lp, input int rdy_pct, input int stop_pass, input int stop_idx,
                       input bit noise, input bit chk_pat);
    int base;
    base  = n_done;
    start = 1'b1;
    loop  = lp;
    tick();
    start  = 1'b0;
    loop   = 1'b0;
    cfg_we = 1'b0;
    for (int c = 0; c < 3000 && m_phase != 0; c++) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      stop = lp && ((n_done - base) == stop_pass) && (int'(out_idx) == stop_idx);
      if (noise && m_phase == 1) begin
        start    = ($urandom_range(3) == 0);
        cfg_we   = ($urandom_range(3) == 0);
        cfg_mask = DEPTH'($urandom);
      end else begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      chk_in = chk_pat ? (def_mask[out_idx] ^ (out_idx == 3 || out_idx == 12)) : 1'($urandom_range(1));
      tick();
    end
    check("sweep_ends_idle", busy, 1'b0);
    out_ready = 1'b0; stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    int exp_sop[6];
    exp_sop = '{2, 6, 7, 12, 14, 15};

    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_idx", out_idx, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    // Default table, no backpressure, with done timing counted from the start cycle as cycle 1.
    acc_q.delete(); sop_q.delete();
    out_ready = 1'b1; start = 1'b1; cyc = 1;
    tick();
    start = 1'b0; cyc = 2;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    check("done_cycle", cyc, 18);
    tick(); tick();
    out_ready = 1'b0;
    check("default_beats", acc_q.size(), 16);
    check("default_sop_count", sop_q.size(), 6);
    for (int i = 0; i < 6 && i < sop_q.size(); i++) check("default_sop_idx", sop_q[i], exp_sop[i]);
    check("default_ones", ones_cnt, 6);

    // Random backpressure: every index exactly once, in order.
    acc_q.delete();
    sweep(1'b0, 50, 0, 0, 1'b0, 1'b0);
    check("bp_beats", acc_q.size(), 16);
    for (int i = 0; i < acc_q.size(); i++) check("bp_order", acc_q[i], i);
    check("bp_ones", ones_cnt, 6);

    // All-zero then all-ones tables; the all-ones load shares its cycle with start.
    cfg_we = 1'b1; cfg_mask = '0;
    tick();
    cfg_we = 1'b0; sop_q.delete();
    sweep(1'b0, 70, 0, 0, 1'b0, 1'b0);
    check("zero_ones", ones_cnt, 0);
    check("zero_sop_beats", sop_q.size(), 0);
    cfg_we = 1'b1; cfg_mask = 16'hFFFF; sop_q.delete();
    sweep(1'b0, 70, 0, 0, 1'b0, 1'b0);
    check("full_ones", ones_cnt, 16);
    check("full_sop_beats", sop_q.size(), 16);

    // Looping sweep stopped at idx 5 of the second pass.
    cfg_we = 1'b1; cfg_mask = 16'hD0C4;
    tick();
    cfg_we = 1'b0;
    acc_q.delete(); d0 = n_done;
    sweep(1'b1, 100, 1, 5, 1'b0, 1'b0);
    check("loop_done_pulses", n_done - d0, 2);
    check("loop_beats", acc_q.size(), 32);
    if (acc_q.size() > 16) begin
      check("loop_wrap_from", acc_q[15], 15);
      check("loop_wrap_to", acc_q[16], 0);
    end
    check("loop_ones", ones_cnt, 6);

    // start during RUN is ignored; reset at idx 9 aborts with no done pulse.
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && out_idx != 4; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_idx", out_idx, 5);
    for (int k = 0; k < 40 && out_idx != 9; k++) tick();
    check("reached_idx9", out_idx, 9);
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_idx", out_idx, 0);
    check("abort_ones", ones_cnt, 0);
    check("abort_done", done, 1'b0);
    tick(); tick();
    check("abort_no_done", n_done, d0);
    out_ready = 1'b0; rst_n = 1'b1;
    tick();

`ifdef CHECK_EN
    sweep(1'b0, 60, 0, 0, 1'b0, 1'b1);
    check("err_cnt_two", err_cnt, 2);
`endif

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(1) == 1) begin
        cfg_we   = 1'b1;
        cfg_mask = DEPTH'($urandom);
      end
      sweep(1'($urandom_range(1)), $urandom_range(30, 100), $urandom_range(0, 2),
            $urandom_range(1, DEPTH - 1), 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
